// File: rtl/regfile_pkg.sv
// Shared constants and types for the multi-port register file.
package regfile_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_ADDR_W = 5;
  localparam int unsigned REG_ZERO   = 0;

  typedef enum logic [1:0] {
    WP_NONE = 2'd0,
    WP_A    = 2'd1,
    WP_B    = 2'd2
  } wport_e;

endpackage

// File: rtl/regfile_rd_port.sv
// One read port: write-to-read bypass selection and pending-hazard masking.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic              i_rst,
  input  logic [ADDR_W-1:0] i_rd_addr,
  input  logic [DATA_W-1:0] i_stored,
  input  logic              i_pend,
  input  logic              i_wa_ok,
  input  logic [ADDR_W-1:0] i_wa_addr,
  input  logic [DATA_W-1:0] i_wa_data,
  input  logic              i_wb_ok,
  input  logic [ADDR_W-1:0] i_wb_addr,
  input  logic [DATA_W-1:0] i_wb_data,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_pending
);

  wport_e w_sel;
  logic   w_is_zero;

  always_comb begin
    w_sel = WP_NONE;
    if (BYPASS != 0) begin
      if (i_wb_ok && (i_wb_addr == i_rd_addr))
        w_sel = WP_B;
      else if (i_wa_ok && (i_wa_addr == i_rd_addr))
        w_sel = WP_A;
    end
  end

  assign w_is_zero = (ZERO_REG != 0) && (i_rd_addr == ADDR_W'(REG_ZERO));

  always_comb begin
    o_rd_data = i_stored;
    case (w_sel)
      WP_B:    o_rd_data = i_wb_data;
      WP_A:    o_rd_data = i_wa_data;
      default: o_rd_data = i_stored;
    endcase
    if (i_rst || w_is_zero)
      o_rd_data = '0;
  end

  // A value being forwarded this cycle already resolves the hazard.
  assign o_rd_pending = i_pend && (w_sel == WP_NONE) && !w_is_zero && !i_rst;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with two write ports, optional bypass and a
// per-register pending scoreboard for decode hazard detection.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int N_RD     = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_RD*ADDR_W-1:0]   rd_addr,
  output logic [N_RD*DATA_W-1:0]   rd_data,
  output logic [N_RD-1:0]          rd_pending,
  input  logic                     wa_en,
  input  logic [ADDR_W-1:0]        wa_addr,
  input  logic [DATA_W-1:0]        wa_data,
  input  logic                     wb_en,
  input  logic [ADDR_W-1:0]        wb_addr,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic                     pend_any
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_regs [DEPTH];
  logic [DEPTH-1:0]  r_pend;

  logic w_wa_ok;
  logic w_wb_ok;
  logic w_iss_ok;

  assign w_wa_ok  = wa_en  && !((ZERO_REG != 0) && (wa_addr  == ADDR_W'(REG_ZERO)));
  assign w_wb_ok  = wb_en  && !((ZERO_REG != 0) && (wb_addr  == ADDR_W'(REG_ZERO)));
  assign w_iss_ok = iss_en && !((ZERO_REG != 0) && (iss_addr == ADDR_W'(REG_ZERO)));

  // Port B is assigned last so it wins an address collision with port A.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++)
        r_regs[i] <= '0;
    end else begin
      if (w_wa_ok)
        r_regs[wa_addr] <= wa_data;
      if (w_wb_ok)
        r_regs[wb_addr] <= wb_data;
    end
  end

  // Issue is assigned after the writeback clears: the younger owner keeps the bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend <= '0;
    end else begin
      if (w_wa_ok)
        r_pend[wa_addr] <= 1'b0;
      if (w_wb_ok)
        r_pend[wb_addr] <= 1'b0;
      if (w_iss_ok)
        r_pend[iss_addr] <= 1'b1;
    end
  end

  assign pend_any = |r_pend;

  for (genvar g = 0; g < N_RD; g++) begin : g_rd
    logic [ADDR_W-1:0] w_addr;
    assign w_addr = rd_addr[g*ADDR_W +: ADDR_W];

    regfile_rd_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .BYPASS   (BYPASS),
      .ZERO_REG (ZERO_REG)
    ) u_rd_port (
      .i_rst        (rst),
      .i_rd_addr    (w_addr),
      .i_stored     (r_regs[w_addr]),
      .i_pend       (r_pend[w_addr]),
      .i_wa_ok      (w_wa_ok),
      .i_wa_addr    (wa_addr),
      .i_wa_data    (wa_data),
      .i_wb_ok      (w_wb_ok),
      .i_wb_addr    (wb_addr),
      .i_wb_data    (wb_data),
      .o_rd_data    (rd_data[g*DATA_W +: DATA_W]),
      .o_rd_pending (rd_pending[g])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a BYPASS=1 and a BYPASS=0 instance share stimulus and
// are checked against an array-based reference model.
module tb_regfile_mp;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR*AW-1:0]  rd_addr;
  logic [NR*DW-1:0]  rd_data_b, rd_data_n;
  logic [NR-1:0]     rdp_b, rdp_n;
  logic              pa_b, pa_n;
  logic              wa_en, wb_en, iss_en;
  logic [AW-1:0]     wa_addr, wb_addr, iss_addr;
  logic [DW-1:0]     wa_data, wb_data;

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] m_regs [32];
  bit            m_pend [32];

  always #5 clk = ~clk;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .N_RD(NR), .BYPASS(1), .ZERO_REG(1)) u_byp (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_pending(rdp_b),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .pend_any(pa_b));

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .N_RD(NR), .BYPASS(0), .ZERO_REG(1)) u_nob (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_pending(rdp_n),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .pend_any(pa_n));

  function automatic logic [DW-1:0] pd(input logic [NR*DW-1:0] v, input int p);
    return v[p*DW +: DW];
  endfunction

  function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a, input bit byp);
    if (rst || a == 0) return '0;
    if (byp && wb_en && wb_addr == a) return wb_data;
    if (byp && wa_en && wa_addr == a) return wa_data;
    return m_regs[a];
  endfunction

  function automatic bit exp_pend(input logic [AW-1:0] a, input bit byp);
    if (rst || a == 0) return 1'b0;
    if (byp && ((wa_en && wa_addr == a) || (wb_en && wb_addr == a))) return 1'b0;
    return m_pend[a];
  endfunction

  function automatic bit exp_any();
    bit r = 1'b0;
    for (int i = 0; i < 32; i++) r |= m_pend[i];
    return r;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = '0;
      m_pend[i] = 1'b0;
    end
  endtask

  task automatic set_rd(input int p, input logic [AW-1:0] a);
    rd_addr[p*AW +: AW] = a;
  endtask

  // Model absorbs the edge using the inputs presented before it.
  task automatic tick();
    if (wa_en && wa_addr != 0) begin m_regs[wa_addr] = wa_data; m_pend[wa_addr] = 1'b0; end
    if (wb_en && wb_addr != 0) begin m_regs[wb_addr] = wb_data; m_pend[wb_addr] = 1'b0; end
    if (iss_en && iss_addr != 0) m_pend[iss_addr] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    wa_en = 1'b0; wb_en = 1'b0; iss_en = 1'b0;
  endtask

  task automatic test_reset();
    set_rd(0, 5'd5); set_rd(1, 5'd5);
    wa_en = 1'b1; wa_addr = 5'd5; wa_data = 32'hDEADBEEF;
    #1;
    for (int p = 0; p < NR; p++) begin
      n_cmp++;
      if (pd(rd_data_b, p) !== '0) begin n_err++; $display("FAIL rst_hold_data p%0d got %h want 0", p, pd(rd_data_b, p)); end
    end
    n_cmp++;
    if (rdp_b !== '0 || rdp_n !== '0 || pa_b !== 1'b0 || pa_n !== 1'b0) begin
      n_err++; $display("FAIL rst_hold_pend got %b %b %b %b want 0", rdp_b, rdp_n, pa_b, pa_n);
    end
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    iss_en = 1'b1; iss_addr = 5'd6;
    tick();
    set_rd(1, 5'd6);
    #1;
    n_cmp++;
    if (pd(rd_data_n, 0) !== 32'hDEADBEEF) begin n_err++; $display("FAIL pre_rst_write got %h want deadbeef", pd(rd_data_n, 0)); end
    n_cmp++;
    if (rdp_n[1] !== 1'b1 || pa_n !== 1'b1) begin n_err++; $display("FAIL pre_rst_pend got %b/%b want 1/1", rdp_n[1], pa_n); end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (pd(rd_data_b, 0) !== '0 || pd(rd_data_n, 0) !== '0) begin
      n_err++; $display("FAIL async_rst_data got %h/%h want 0", pd(rd_data_b, 0), pd(rd_data_n, 0));
    end
    n_cmp++;
    if (rdp_b !== '0 || rdp_n !== '0 || pa_b !== 1'b0 || pa_n !== 1'b0) begin
      n_err++; $display("FAIL async_rst_pend got %b %b %b %b want 0", rdp_b, rdp_n, pa_b, pa_n);
    end
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++;
    if (pd(rd_data_n, 0) !== '0) begin n_err++; $display("FAIL post_rst_data got %h want 0", pd(rd_data_n, 0)); end
  endtask

  task automatic test_write_nobypass();
    wa_en = 1'b1; wa_addr = 5'd3; wa_data = 32'h12345678;
    set_rd(0, 5'd3); set_rd(1, 5'd3);
    #1;
    for (int p = 0; p < NR; p++) begin
      n_cmp++;
      if (pd(rd_data_n, p) !== '0) begin n_err++; $display("FAIL nob_same_cycle p%0d got %h want 0", p, pd(rd_data_n, p)); end
      n_cmp++;
      if (pd(rd_data_b, p) !== 32'h12345678) begin n_err++; $display("FAIL byp_same_cycle p%0d got %h want 12345678", p, pd(rd_data_b, p)); end
    end
    tick();
    #1;
    for (int p = 0; p < NR; p++) begin
      n_cmp++;
      if (pd(rd_data_n, p) !== 32'h12345678 || pd(rd_data_b, p) !== 32'h12345678) begin
        n_err++; $display("FAIL write_next_cycle p%0d got %h/%h want 12345678", p, pd(rd_data_n, p), pd(rd_data_b, p));
      end
    end
  endtask

  task automatic test_collision();
    wa_en = 1'b1; wa_addr = 5'd7; wa_data = 32'h1;
    wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h2;
    set_rd(0, 5'd7); set_rd(1, 5'd3);
    #1;
    n_cmp++;
    if (pd(rd_data_b, 0) !== 32'h2) begin n_err++; $display("FAIL coll_bypass got %h want 2", pd(rd_data_b, 0)); end
    n_cmp++;
    if (pd(rd_data_n, 0) !== '0 || pd(rd_data_n, 1) !== 32'h12345678) begin
      n_err++; $display("FAIL coll_nob_read got %h/%h want 0/12345678", pd(rd_data_n, 0), pd(rd_data_n, 1));
    end
    tick();
    #1;
    n_cmp++;
    if (pd(rd_data_b, 0) !== 32'h2 || pd(rd_data_n, 0) !== 32'h2) begin
      n_err++; $display("FAIL coll_stored got %h/%h want 2", pd(rd_data_b, 0), pd(rd_data_n, 0));
    end
  endtask

  task automatic test_zero();
    wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFFFFFF;
    iss_en = 1'b1; iss_addr = 5'd0;
    set_rd(0, 5'd0); set_rd(1, 5'd0);
    for (int k = 0; k < 2; k++) begin
      #1;
      n_cmp++;
      if (pd(rd_data_b, 0) !== '0 || pd(rd_data_n, 0) !== '0) begin
        n_err++; $display("FAIL zero_data c%0d got %h/%h want 0", k, pd(rd_data_b, 0), pd(rd_data_n, 0));
      end
      n_cmp++;
      if (rdp_b !== '0 || rdp_n !== '0 || pa_b !== 1'b0 || pa_n !== 1'b0) begin
        n_err++; $display("FAIL zero_pend c%0d got %b %b %b %b want 0", k, rdp_b, rdp_n, pa_b, pa_n);
      end
      if (k == 0) tick();
    end
  endtask

  task automatic test_scoreboard();
    iss_en = 1'b1; iss_addr = 5'd9;
    set_rd(0, 5'd9);
    tick();
    #1;
    n_cmp++;
    if (rdp_b[0] !== 1'b1 || rdp_n[0] !== 1'b1 || pa_b !== 1'b1) begin
      n_err++; $display("FAIL sb_issue got %b/%b/%b want 1/1/1", rdp_b[0], rdp_n[0], pa_b);
    end
    wa_en = 1'b1; wa_addr = 5'd9; wa_data = 32'hAA;
    iss_en = 1'b1; iss_addr = 5'd9;
    #1;
    n_cmp++;
    if (rdp_b[0] !== 1'b0 || rdp_n[0] !== 1'b1) begin
      n_err++; $display("FAIL sb_write_mask got %b/%b want 0/1", rdp_b[0], rdp_n[0]);
    end
    tick();
    #1;
    n_cmp++;
    if (rdp_b[0] !== 1'b1 || rdp_n[0] !== 1'b1 || pd(rd_data_n, 0) !== 32'hAA) begin
      n_err++; $display("FAIL sb_set_wins got %b/%b data %h want 1/1 data aa", rdp_b[0], rdp_n[0], pd(rd_data_n, 0));
    end
    wa_en = 1'b1; wa_addr = 5'd9; wa_data = 32'hBB;
    tick();
    #1;
    n_cmp++;
    if (rdp_b[0] !== 1'b0 || rdp_n[0] !== 1'b0 || pa_b !== 1'b0 || pa_n !== 1'b0) begin
      n_err++; $display("FAIL sb_clear got %b %b %b %b want 0", rdp_b[0], rdp_n[0], pa_b, pa_n);
    end
    n_cmp++;
    if (pd(rd_data_b, 0) !== 32'hBB) begin n_err++; $display("FAIL sb_data got %h want bb", pd(rd_data_b, 0)); end
  endtask

  task automatic test_pend_mask();
    iss_en = 1'b1; iss_addr = 5'd4;
    set_rd(1, 5'd4);
    tick();
    wa_en = 1'b1; wa_addr = 5'd4; wa_data = 32'h55;
    #1;
    n_cmp++;
    if (rdp_b[1] !== 1'b0 || pd(rd_data_b, 1) !== 32'h55) begin
      n_err++; $display("FAIL mask_byp got %b data %h want 0 data 55", rdp_b[1], pd(rd_data_b, 1));
    end
    n_cmp++;
    if (rdp_n[1] !== 1'b1 || pd(rd_data_n, 1) !== '0) begin
      n_err++; $display("FAIL mask_nob got %b data %h want 1 data 0", rdp_n[1], pd(rd_data_n, 1));
    end
    tick();
    #1;
    n_cmp++;
    if (rdp_n[1] !== 1'b0 || pd(rd_data_n, 1) !== 32'h55) begin
      n_err++; $display("FAIL mask_after got %b data %h want 0 data 55", rdp_n[1], pd(rd_data_n, 1));
    end
  endtask

  task automatic test_random();
    logic [AW-1:0] a;
    logic [DW-1:0] got_d;
    bit            got_p;
    rst = 1'b1;
    #1 model_clear();
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 400; c++) begin
      wa_en = 1'($urandom_range(0, 1)); wa_addr = AW'($urandom_range(0, 7)); wa_data = $urandom;
      wb_en = 1'($urandom_range(0, 1)); wb_addr = AW'($urandom_range(0, 7)); wb_data = $urandom;
      iss_en = 1'($urandom_range(0, 1)); iss_addr = AW'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) wa_addr = AW'($urandom);
      for (int p = 0; p < NR; p++) set_rd(p, AW'($urandom_range(0, 7)));
      #1;
      for (int p = 0; p < NR; p++) begin
        a = rd_addr[p*AW +: AW];
        for (int b = 0; b < 2; b++) begin
          got_d = (b == 1) ? pd(rd_data_b, p) : pd(rd_data_n, p);
          got_p = (b == 1) ? rdp_b[p] : rdp_n[p];
          n_cmp++;
          if (got_d !== exp_data(a, b[0]) || got_p !== exp_pend(a, b[0])) begin
            n_err++;
            $display("FAIL rand c%0d byp%0d p%0d r%0d got %h/%b want %h/%b", c, b, p, a,
                     got_d, got_p, exp_data(a, b[0]), exp_pend(a, b[0]));
          end
        end
      end
      n_cmp++;
      if (pa_b !== exp_any() || pa_n !== exp_any()) begin
        n_err++; $display("FAIL rand_pend_any c%0d got %b/%b want %b", c, pa_b, pa_n, exp_any());
      end
      tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    rd_addr = '0;
    wa_en = 1'b0; wa_addr = '0; wa_data = '0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    iss_en = 1'b0; iss_addr = '0;
    model_clear();
    test_reset();
    test_write_nobypass();
    test_collision();
    test_zero();
    test_scoreboard();
    test_pend_mask();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port general-purpose register file for the pipelined CPU core.
- Generalises the single-cycle 32x32 2R1W file to N_RD read ports, two write ports (ALU writeback, memory writeback) and optional same-cycle write-to-read bypass.
- Adds a per-register pending scoreboard: issue sets the bit, writeback clears it; decode uses it for hazard stalls.
- Sits between decode (read/issue) and writeback stages.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register index width; depth = 2**ADDR_W.
- N_RD, 2, number of read ports (1..4).
- BYPASS, 1, 1 = forward same-cycle write data to reads; 0 = reads see the stored value only.
- ZERO_REG, 1, 1 = register 0 hardwired to zero and never pending.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- rd_addr  in  N_RD*ADDR_W  read indices; port i = bits [i*ADDR_W +: ADDR_W].
- rd_data  out  N_RD*DATA_W  read data, combinational; port i = bits [i*DATA_W +: DATA_W].
- rd_pending  out  N_RD  port i: the register addressed by rd_addr port i has an outstanding write.
- wa_en  in  1  write port A enable (ALU writeback).
- wa_addr  in  ADDR_W  write port A index.
- wa_data  in  DATA_W  write port A data.
- wb_en  in  1  write port B enable (memory writeback).
- wb_addr  in  ADDR_W  write port B index.
- wb_data  in  DATA_W  write port B data.
- iss_en  in  1  an instruction with a destination issues this cycle.
- iss_addr  in  ADDR_W  destination of the issuing instruction.
- pend_any  out  1  OR of all pending bits.

Behaviour:
- Reset (async assert, sync-free deassert): all registers = 0 and all pending bits = 0. While rst is high: rd_data = 0 on all ports, rd_pending = 0, pend_any = 0.
- Write: on posedge clk, a register is written if its port enable is high and its address is non-zero (or ZERO_REG = 0).
- Write collision (wa_en & wb_en, wa_addr == wb_addr): port B wins; port A data is dropped for that register.
- Register 0 with ZERO_REG = 1:
  - writes are ignored;
  - reads return 0, including under bypass;
  - its pending bit is never set.
- Read: combinational, zero latency.
- Read with BYPASS = 1: priority is wb_data (wb_en, address match, non-zero) > wa_data (wa_en, address match, non-zero) > stored value.
- Read with BYPASS = 0: returns the stored value; newly written data is visible in the cycle after the write edge.
- Pending set: on posedge clk when iss_en, pending[iss_addr] <= 1.
- Pending clear: on posedge clk, a write on either port clears pending[addr].
- Simultaneous set and clear on the same register: set wins. The pending bit stays 1 because the younger instruction now owns the register.
- rd_pending[i]: pending[rd_addr_i], masked to 0 when BYPASS = 1 and a write to that address is active this cycle (the bypassed value resolves the hazard).
- No counters per register. A second issue to an already-pending register leaves the bit at 1; the pipeline guarantees in-order writeback per register.
- Reset asserted mid-operation: state clears immediately, independent of clk. The first write is accepted on the first rising edge after deassertion.
- No X propagation: unused address bits are impossible since depth = 2**ADDR_W.

Decomposition:
- Shared package regfile_pkg: default DATA_W/ADDR_W, the REG_ZERO index constant, and the write-port priority encoding (WP_NONE, WP_A, WP_B).
- One sub-module: regfile_rd_port, the per-read-port bypass mux plus pending masking, instantiated N_RD times via generate.
- Storage, write logic and scoreboard stay in the top level.

Test Plan:
- Reset: write 0xDEADBEEF to r5, then pulse rst asynchronously between edges -> rd_data for r5 = 0 immediately; rd_pending = 0; pend_any = 0.
- Write and read with BYPASS = 0: wa writes r3 = 0x12345678 -> same cycle reads old value 0; next cycle reads 0x12345678 on all N_RD ports.
- Bypass and collision with BYPASS = 1: wa_data = 0x1, wb_data = 0x2, both to r7 -> same-cycle read of r7 = 0x2; stored value next cycle = 0x2.
- Zero register: wb writes r0 = 0xFFFFFFFF with iss_en to r0 -> r0 reads 0 in the same and next cycle; rd_pending = 0; pend_any stays 0.
- Scoreboard: issue r9 -> next cycle rd_pending = 1 for r9. Write r9 = 0xAA while issuing r9 again -> pending stays 1, r9 = 0xAA. Write r9 with no issue -> pending 0; pend_any drops to 0.
- Pending masking with BYPASS = 1: r4 pending, wa writes r4 = 0x55 this cycle -> rd_pending for r4 = 0 and rd_data = 0x55 in the same cycle.
